// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM, one-cycle data-valid strobe.
// Optional stop-bit framing check and o_Rx_Frame_Err port are enabled with `define UART_RX_FRAME_ERR_EN.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic       o_Rx_Frame_Err
`endif
);

  // state   | meaning
  // IDLE    | waiting for a falling edge on the synchronized line
  // START   | counting to the middle of the start bit, rejecting glitches
  // DATA    | sampling eight data bits LSB first, one per bit period
  // STOP    | sampling the stop bit one bit period after the last data bit
  // CLEANUP | single cycle in which the byte/strobe are presented
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4
  } state_e;

  localparam logic [15:0] MID_CNT  = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  logic        rx_meta_q, rx_sync_q, rx_prev_q;
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        dv_q, dv_d;
`ifdef UART_RX_FRAME_ERR_EN
  logic        err_q, err_d;
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      idx_q     <= 3'd0;
      shift_q   <= 8'h00;
      byte_q    <= 8'h00;
      dv_q      <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      dv_q      <= dv_d;
`ifdef UART_RX_FRAME_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    dv_d    = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        // Edge, not level: a line stuck low never starts a frame.
        if (rx_prev_q && !rx_sync_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == MID_CNT) begin
          cnt_d   = 16'd0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = 16'd0;
          shift_d[idx_q] = rx_sync_q;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 16'd0;
          state_d = S_CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
          if (rx_sync_q) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
`else
          byte_d = shift_q;
          dv_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CLEANUP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign o_Rx_DV     = dv_q;
  assign o_Rx_Byte   = byte_q;
  assign o_Rx_Active = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
`ifdef UART_RX_FRAME_ERR_EN
  assign o_Rx_Frame_Err = err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT=16: directed table, corner sequences, random frames.
// Builds with or without UART_RX_FRAME_ERR_EN.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dv;
  logic [7:0] rbyte;
  logic       active;
`ifdef UART_RX_FRAME_ERR_EN
  logic       ferr;
  logic       prev_err = 1'b0;
`endif

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_Serial (rx),
    .o_Rx_DV     (dv),
    .o_Rx_Byte   (rbyte),
    .o_Rx_Active (active)
`ifdef UART_RX_FRAME_ERR_EN
    ,
    .o_Rx_Frame_Err (ferr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] b;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    bit         stop_ok;
    int         gap;
    ev_t        exp;
  } vec_t;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  fall_cyc = 0;
  int  dv_cyc = 0;
  logic prev_dv = 1'b0;
  logic [7:0] last_byte = 8'h00;
  ev_t obs_q[$];
  ev_t exp_q[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (dv) begin
      check("dv_width", {31'd0, prev_dv}, 32'd0);
      obs_q.push_back('{1'b0, rbyte});
      dv_cyc = cyc;
    end
    prev_dv <= dv;
`ifdef UART_RX_FRAME_ERR_EN
    if (ferr) begin
      check("err_width", {31'd0, prev_err}, 32'd0);
      obs_q.push_back('{1'b1, 8'h00});
    end
    prev_err <= ferr;
`endif
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int gap);
    int g;
    g = gap;
    fall_cyc = cyc;
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop_ok, CPB);
    if (!stop_ok && g < CPB) g = CPB;
    if (g > 0) drive(1'b1, g);
  endtask

  // Reference: what one completed frame must produce at the outputs.
  function automatic ev_t model_frame(input logic [7:0] b, input bit stop_ok);
    ev_t e;
`ifdef UART_RX_FRAME_ERR_EN
    if (stop_ok) e = '{1'b0, b};
    else         e = '{1'b1, 8'h00};
`else
    e = '{1'b0, b};
`endif
    return e;
  endfunction

  task automatic compare_events();
    int n;
    check("event_count", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("event_kind", {31'd0, obs_q[i].is_err}, {31'd0, exp_q[i].is_err});
      check("event_byte", {24'd0, obs_q[i].b}, {24'd0, exp_q[i].b});
    end
    for (int i = 0; i < exp_q.size(); i++)
      if (!exp_q[i].is_err) last_byte = exp_q[i].b;
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 32, '{1'b0, 8'hA5}};
    vecs[1] = '{8'h00, 1'b1, 0,  '{1'b0, 8'h00}};
    vecs[2] = '{8'hFF, 1'b1, 0,  '{1'b0, 8'hFF}};
    vecs[3] = '{8'h3C, 1'b1, 20, '{1'b0, 8'h3C}};
`ifdef UART_RX_FRAME_ERR_EN
    vecs[4] = '{8'h55, 1'b0, 20, '{1'b1, 8'h00}};
`else
    vecs[4] = '{8'h55, 1'b0, 20, '{1'b0, 8'h55}};
`endif
    vecs[5] = '{8'h81, 1'b1, 20, '{1'b0, 8'h81}};

    rx = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_dv", {31'd0, dv}, 32'd0);
    check("reset_byte", {24'd0, rbyte}, 32'h00);
    check("reset_active", {31'd0, active}, 32'd0);
`ifdef UART_RX_FRAME_ERR_EN
    check("reset_ferr", {31'd0, ferr}, 32'd0);
`endif
    rst_n = 1'b1;
    drive(1'b1, 2 * CPB);

    // Directed table; entries 1..3 run back-to-back with no idle gap.
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].gap);
      exp_q.push_back(vecs[i].exp);
      compare_events();
      if (!vecs[i].exp.is_err)
        check("dv_latency", {31'd0, ((dv_cyc - fall_cyc) >= 150) && ((dv_cyc - fall_cyc) <= 160)}, 32'd1);
      check("byte_hold", {24'd0, rbyte}, {24'd0, last_byte});
      check("active_after", {31'd0, active}, 32'd0);
    end

    // Short low glitch on an idle line.
    drive(1'b0, 4);
    drive(1'b1, 3 * CPB);
    compare_events();
    check("glitch_byte", {24'd0, rbyte}, {24'd0, last_byte});
    check("glitch_active", {31'd0, active}, 32'd0);

    // Reset during data bit 4 of 0x81.
    drive(1'b0, CPB);
    drive(1'b1, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB);
    drive(1'b0, CPB / 2);
    check("midframe_active", {31'd0, active}, 32'd1);
    rst_n = 1'b0;
    drive(1'b1, 5);
    rst_n = 1'b1;
    drive(1'b1, 2 * CPB);
    compare_events();
    last_byte = 8'h00;
    check("abort_byte", {24'd0, rbyte}, 32'h00);
    check("abort_active", {31'd0, active}, 32'd0);
    send_frame(8'h81, 1'b1, 20);
    exp_q.push_back(model_frame(8'h81, 1'b1));
    compare_events();
    check("after_reset_byte", {24'd0, rbyte}, 32'h81);

    // Line held low for 30 bit periods: exactly one frame event, then silence.
    drive(1'b0, 30 * CPB);
    drive(1'b1, 3 * CPB);
    exp_q.push_back(model_frame(8'h00, 1'b0));
    compare_events();
    check("stuck_low_byte", {24'd0, rbyte}, {24'd0, last_byte});
    check("stuck_low_active", {31'd0, active}, 32'd0);

    // Random frames against the frame-level model.
    for (int k = 0; k < 40; k++) begin
      logic [7:0] b;
      bit ok;
      int gap;
      b   = 8'($urandom_range(0, 255));
      ok  = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 20);
      send_frame(b, ok, gap);
      exp_q.push_back(model_frame(b, ok));
      compare_events();
      check("rand_byte_hold", {24'd0, rbyte}, {24'd0, last_byte});
    end

    drive(1'b1, 2 * CPB);
    check("final_active", {31'd0, active}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, giving i_Clock cycles per serial bit; legal range 4..65535.
REQ-002 SHALL have port i_Clock  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port i_Rx_Serial  input  1  asynchronous serial line, idle high.
REQ-005 SHALL have port o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a newly received byte.
REQ-006 SHALL have port o_Rx_Byte  output  8  last received data byte.
REQ-007 SHALL have port o_Rx_Active  output  1  high from start-bit detection until return to IDLE.
REQ-008 SHALL have port o_Rx_Frame_Err  output  1  one-cycle pulse on a bad stop bit; present only with UART_RX_FRAME_ERR_EN.

Function
REQ-009 SHALL pass i_Rx_Serial through a two-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-010 SHALL keep a 16-bit clock counter and a 3-bit bit index.
REQ-011 SHALL implement FSM states IDLE, START, DATA, STOP, CLEANUP.
REQ-012 IDLE: counter and index held at 0; a high-to-low transition of the synchronized line SHALL move the FSM to START.
REQ-013 IDLE: a line that is continuously low SHALL NOT trigger reception.
REQ-014 START: the counter SHALL increment until it equals (CLKS_PER_BIT-1)/2 (integer division).
REQ-015 START, at the mid-bit count: a low line SHALL clear the counter and move to DATA; a high line SHALL count as a glitch and return to IDLE with no output pulse.
REQ-016 DATA: at counter == CLKS_PER_BIT-1 the line SHALL be stored into the shift register at the bit index (LSB first), the counter cleared and the index incremented.
REQ-017 DATA: after bit index 7 is stored, the index SHALL wrap to 0 and the FSM SHALL move to STOP.
REQ-018 STOP: at counter == CLKS_PER_BIT-1 the line SHALL be sampled as the stop bit and the FSM SHALL move to CLEANUP.
REQ-019 CLEANUP: lasts exactly one cycle, then IDLE.
REQ-020 CLEANUP, valid frame: o_Rx_Byte SHALL update and o_Rx_DV SHALL be high in this one cycle only.
REQ-021 o_Rx_Byte SHALL otherwise hold its value until the next valid frame.
REQ-022 o_Rx_Active SHALL be 1 in START, DATA and STOP, and 0 in IDLE and CLEANUP.
REQ-023 A falling edge that arrives during CLEANUP SHALL be ignored.
REQ-024 Back-to-back frames with a one-bit stop and no idle gap SHALL all be received.
REQ-025 Any unused FSM encoding SHALL return to IDLE on the next cycle.

Reset
REQ-026 While i_Rst_n=0 at a clock edge: FSM=IDLE, counter=0, index=0, shift register=0, o_Rx_Byte=0x00, o_Rx_DV=0, o_Rx_Active=0, o_Rx_Frame_Err=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no DV or error pulse.
REQ-028 After reset release, reception SHALL begin only on a fresh falling edge.

Configuration
REQ-029 Macro UART_RX_FRAME_ERR_EN defined: a stop bit sampled low SHALL suppress o_Rx_DV and leave o_Rx_Byte unchanged.
REQ-030 Macro UART_RX_FRAME_ERR_EN defined: in that CLEANUP cycle o_Rx_Frame_Err SHALL pulse high for exactly one cycle.
REQ-031 Macro UART_RX_FRAME_ERR_EN undefined: the o_Rx_Frame_Err port SHALL be absent, the stop bit value SHALL be ignored, and every completed frame SHALL assert o_Rx_DV.

Verification (CLKS_PER_BIT=16)
REQ-032 Serial frame 0xA5 with a valid stop bit -> o_Rx_Byte=0xA5; o_Rx_DV high exactly one cycle, 150..160 cycles after the line falls; o_Rx_Active low afterwards.
REQ-033 Low glitch of 4 cycles on an idle line -> no o_Rx_DV, FSM back in IDLE, o_Rx_Byte unchanged.
REQ-034 Frames 0x00, 0xFF, 0x3C sent back-to-back with no idle gap -> three o_Rx_DV pulses with bytes 0x00, 0xFF, 0x3C in order.
REQ-035 Frame 0x55 with the stop bit driven low, macro defined -> o_Rx_Frame_Err pulses once, no o_Rx_DV, o_Rx_Byte keeps its prior value; macro undefined -> o_Rx_DV pulses with 0x55.
REQ-036 i_Rst_n driven low during data bit 4 of frame 0x81, then released -> no DV or error pulse, o_Rx_Byte=0x00; the next frame 0x81 is received correctly.
REQ-037 Line held low for 30 bit periods, then released high -> at most one frame event (frame error with macro defined, DV with 0x00 without it), then no further activity until a new falling edge.
